// File: rtl/mem_bus_arbiter.sv
// Merges instruction-fetch and data masters onto one memory/IO bus; grant is one cycle after request.
// Acks route combinationally to the owner; a grant is held until q_m_ack, with one IDLE cycle between transfers.
module mem_bus_arbiter #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_io,
  input  logic [15:0] q_m_data_in,
  input  logic        q_m_ack
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } state_t;

  typedef struct packed {
    logic [19:1] addr;
    logic [15:0] dat;
    logic        wr_en;
    logic [1:0]  bytesel;
    logic        io;
  } bus_req_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  state_t     state;
  logic [3:0] burst_cnt;
  logic       last_grant_data;
  logic       access_q;
  logic       force_instr;
  bus_req_t   instr_req;
  bus_req_t   data_req;
  bus_req_t   bus_req;

  // burst_cnt is only ever non-zero after a data completion, so the
  // last_grant term never changes the outcome; it just documents ownership.
  assign force_instr = last_grant_data && (burst_cnt == BURST_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      burst_cnt       <= 4'd0;
      last_grant_data <= 1'b0;
      access_q        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (instr_m_access && (!data_m_access || force_instr)) begin
            state    <= GRANT_INSTR;
            access_q <= 1'b1;
          end else if (data_m_access) begin
            state    <= GRANT_DATA;
            access_q <= 1'b1;
          end
        end
        GRANT_INSTR: begin
          if (q_m_ack) begin
            state           <= IDLE;
            access_q        <= 1'b0;
            last_grant_data <= 1'b0;
            burst_cnt       <= 4'd0;
          end
        end
        GRANT_DATA: begin
          if (q_m_ack) begin
            state           <= IDLE;
            access_q        <= 1'b0;
            last_grant_data <= 1'b1;
            // Count only data grants that made a pending fetch wait.
            if (!instr_m_access) begin
              burst_cnt <= 4'd0;
            end else if (burst_cnt != BURST_MAX) begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          access_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_req = '{addr: instr_m_addr, dat: 16'h0000, wr_en: 1'b0, bytesel: 2'b11, io: 1'b0};
  assign data_req  = '{addr: data_m_addr, dat: data_m_data_out, wr_en: data_m_wr_en,
                       bytesel: data_m_bytesel, io: d_io};

  always_comb begin
    bus_req = '0;
    unique case (state)
      GRANT_INSTR: bus_req = instr_req;
      GRANT_DATA:  bus_req = data_req;
      default:     bus_req = '0;
    endcase
  end

  assign q_m_addr     = bus_req.addr;
  assign q_m_data_out = bus_req.dat;
  assign q_m_wr_en    = bus_req.wr_en;
  assign q_m_bytesel  = bus_req.bytesel;
  assign q_io         = bus_req.io;
  assign q_m_access   = access_q;

  assign instr_m_ack = (state == GRANT_INSTR) && q_m_ack;
  assign data_m_ack  = (state == GRANT_DATA) && q_m_ack;

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the CPU core.
- Merges the core's instruction-fetch bus and data bus into the single shared memory/IO bus that feeds the system memory controller.
- Arbitrates between the two masters and drives the granted master's request onto the shared bus. Only one master is active at a time; the request held active is the granted one.
- Routes read data and acknowledge back to the granted master only, using a bounded-starvation priority scheme.

Parameters:
- MAX_DATA_BURST, 4: maximum consecutive data grants while an instruction request is pending; the next grant is then forced to the instruction bus. Legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- instr_m_addr  input  19  instruction fetch word address [19:1]
- instr_m_access  input  1  instruction fetch request
- instr_m_ack  output  1  instruction fetch complete, one cycle
- instr_m_data_in  output  16  instruction read data
- data_m_addr  input  19  data word address [19:1]
- data_m_data_out  input  16  data write data from core
- data_m_access  input  1  data request
- data_m_wr_en  input  1  data request is a write
- data_m_bytesel  input  2  data byte lanes
- d_io  input  1  data request targets IO space
- data_m_ack  output  1  data transfer complete, one cycle
- data_m_data_in  output  16  data read data
- q_m_addr  output  19  shared bus address
- q_m_data_out  output  16  shared bus write data
- q_m_access  output  1  shared bus request
- q_m_wr_en  output  1  shared bus write strobe
- q_m_bytesel  output  2  shared bus byte lanes
- q_io  output  1  shared bus IO select
- q_m_data_in  input  16  shared bus read data
- q_m_ack  input  1  shared bus transfer complete

Behaviour:

State machine: IDLE, GRANT_INSTR, GRANT_DATA, held in registers. Registered state also holds burst_cnt (4 bits) and last_grant.

Reset (reset low, asynchronous):
- Forces IDLE, burst_cnt=0, last_grant=instr.
- All q_m_* outputs 0; q_m_bytesel 2'b00.
- instr_m_ack=0 and data_m_ack=0.
- A transfer in flight is abandoned; a q_m_ack arriving while in reset is ignored.

IDLE:
- All q_m_* outputs 0 and both acks 0.
- Arbitration happens at the clock edge, using the current instr_m_access and data_m_access:
  - Neither asserted: stay in IDLE.
  - Only one asserted: grant that master.
  - Both asserted: grant instr if burst_cnt == MAX_DATA_BURST; otherwise grant data.
- Latency: access sampled high at edge N gives q_m_access=1 during cycle N+1.

GRANT_DATA:
- q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel and q_io follow the data inputs combinationally.
- q_m_access=1.

GRANT_INSTR:
- q_m_addr=instr_m_addr, q_m_data_out=0, q_m_wr_en=0, q_m_bytesel=2'b11, q_io=0.
- q_m_access=1.

Ack routing:
- q_m_ack=1 in GRANT_X gives X_m_ack=1 in the same cycle (combinational); the other master's ack stays 0.
- On that edge the state returns to IDLE and last_grant=X.

burst_cnt:
- Increments on a data-grant completion when instr_m_access was high in that cycle, saturating at MAX_DATA_BURST.
- Clears on any instr completion.
- Clears on a data completion when instr_m_access was low in that cycle.

Read data:
- instr_m_data_in and data_m_data_in both mirror q_m_data_in continuously.
- The data is valid only in the ack cycle.

Back-to-back:
- Each transfer has a one-cycle IDLE gap (ack edge, then IDLE, then the next grant).
- A master holding access high after its ack is re-arbitrated normally.

Boundary conditions:
- Access dropped while granted: q_m_access stays 1 until q_m_ack. The arbiter never aborts a granted transfer.
- q_m_ack in IDLE: ignored; no ack is forwarded.
- Simultaneous new requests with the ack edge: not arbitrated until the IDLE cycle.
- MAX_DATA_BURST=1: with both masters continuously requesting, grants strictly alternate.

Test Plan:
- Single instr fetch: instr_m_addr=0x7FFF8, access pulsed; memory acks 2 cycles after q_m_access. Required: q_m_addr=0x7FFF8, wr_en=0, bytesel=11; instr_m_ack for 1 cycle with data 0xBEEF; data_m_ack stays 0.
- Data IO write: data_m_addr=0x00040, data 0x1234, wr_en=1, bytesel=01, d_io=1. Required: identical values on q_*, q_io=1, data_m_ack asserted in the cycle of q_m_ack.
- Contention (MAX_DATA_BURST=4): both masters request continuously. Required grant sequence D,D,D,D,I,D,D,D,D,I…; each transfer separated by exactly one IDLE cycle.
- Requester drops access mid-transfer: data access deasserted one cycle after grant. Required: q_m_access held until q_m_ack; data_m_ack still pulses.
- Reset mid-transfer: reset low during GRANT_DATA, q_m_ack arrives during reset. Required: q_m_access=0 and both acks 0 immediately; after release the arbiter is in IDLE with burst_cnt=0.
- Stray ack: q_m_ack=1 with no request outstanding. Required: no ack forwarded and state remains IDLE.
